clut_prom_arbiter: RTL and testbench

Time-multiplexes one external 8-bit memory between the two System86 colour lookup PROM images: 3R (red/green, 8-bit) and 3S (blue, 4-bit). Runs on a fast memory clock and serves each lookup with a req/ack handshake. Sits between the videogen subsystem's PROM memory buses and the board-level ROM/SRAM holding the PROM dumps, replacing two dedicated memories with one shared device.

---
 rtl/clut_prom_arbiter.sv | 148 ++++++++++++++
 tb/tb_clut_prom_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clut_prom_arbiter.sv
// Shares one external 8-bit memory between the 3R (red/green) and 3S (blue) CLUT PROM images.
// Optional per-port last-address cache enabled by defining CLUT_ARB_CACHE_EN.
module clut_prom_arbiter #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_3R     = 16'h0000,
  parameter logic [ADDR_WIDTH-1:0] BASE_3S     = 16'h0200,
  parameter int                    WAIT_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic [8:0]            a_addr,
  output logic [7:0]            a_data,
  output logic                  a_ack,
  input  logic                  b_req,
  input  logic [8:0]            b_addr,
  output logic [3:0]            b_data,
  output logic                  b_ack,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_ce_n,
  output logic                  mem_oe_n,
  input  logic [7:0]            mem_data,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, CAPTURE} state_t;

  state_t                state_reg;
  logic [3:0]            cnt_reg;
  logic                  last_b_reg;
  logic                  gnt_b_reg;
  logic                  grant_b_next;
  logic                  grant_any;
  logic                  load_data;
  logic [1:0]            hit;
  logic [ADDR_WIDTH-1:0] a_full;
  logic [ADDR_WIDTH-1:0] b_full;

  // Sums wrap naturally at ADDR_WIDTH bits.
  assign a_full = BASE_3R + ADDR_WIDTH'(a_addr);
  assign b_full = BASE_3S + ADDR_WIDTH'(b_addr);

  // last_b_reg high means B was served last, so A wins a tie.
  assign grant_any    = a_req || b_req;
  assign grant_b_next = b_req && (!a_req || !last_b_reg);

  assign load_data = ((state_reg == ADDR) && (WAIT_CYCLES == 0)) ||
                     ((state_reg == WAIT) && (cnt_reg == 4'd0));

`ifdef CLUT_ARB_CACHE_EN
  logic [8:0] port_addr [2];
  logic [1:0] fill;

  assign port_addr[0] = a_addr;
  assign port_addr[1] = b_addr;

  for (genvar gi = 0; gi < 2; gi++) begin : g_tag
    logic [8:0] tag_reg;
    logic       valid_reg;

    assign fill[gi] = load_data && (gnt_b_reg == (gi == 1));
    assign hit[gi]  = valid_reg && (tag_reg == port_addr[gi]);

    always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
        tag_reg   <= 9'd0;
        valid_reg <= 1'b0;
      end else if (fill[gi]) begin
        tag_reg   <= port_addr[gi];
        valid_reg <= 1'b1;
      end
    end
  end
`else
  assign hit = 2'b00;
`endif

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= 4'd0;
      last_b_reg <= 1'b1;
      gnt_b_reg  <= 1'b0;
      a_data     <= 8'd0;
      b_data     <= 4'd0;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      mem_addr   <= '0;
      mem_ce_n   <= 1'b1;
      mem_oe_n   <= 1'b1;
      busy       <= 1'b0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_any) begin
            gnt_b_reg <= grant_b_next;
            busy      <= 1'b1;
            if (hit[grant_b_next]) begin
              // Cached result already sits in x_data; just acknowledge.
              state_reg <= CAPTURE;
              a_ack     <= !grant_b_next;
              b_ack     <= grant_b_next;
            end else begin
              state_reg <= ADDR;
              mem_addr  <= grant_b_next ? b_full : a_full;
              mem_ce_n  <= 1'b0;
              mem_oe_n  <= 1'b0;
            end
          end
        end
        ADDR: begin
          if (WAIT_CYCLES == 0) begin
            state_reg <= CAPTURE;
          end else begin
            state_reg <= WAIT;
            cnt_reg   <= 4'(WAIT_CYCLES - 1);
          end
        end
        WAIT: begin
          if (cnt_reg == 4'd0) state_reg <= CAPTURE;
          else                 cnt_reg   <= cnt_reg - 4'd1;
        end
        CAPTURE: begin
          state_reg  <= IDLE;
          busy       <= 1'b0;
          mem_ce_n   <= 1'b1;
          mem_oe_n   <= 1'b1;
          last_b_reg <= gnt_b_reg;
        end
        default: state_reg <= IDLE;
      endcase

      // Data and ack register on the edge entering CAPTURE so both are valid together.
      if (load_data) begin
        if (gnt_b_reg) begin
          b_data <= mem_data[3:0];
          b_ack  <= 1'b1;
        end else begin
          a_data <= mem_data;
          a_ack  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clut_prom_arbiter.sv
// Self-checking bench for clut_prom_arbiter: directed vector table, reset/continuous sequences,
// and randomized requests checked against a transaction-level model.
module tb_clut_prom_arbiter;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        a_req = 1'b0, b_req = 1'b0;
  logic [8:0]  a_addr = '0, b_addr = '0;
  logic [7:0]  a_data, mem_data, a_data2, mem_data2;
  logic [3:0]  b_data, b_data2;
  logic        a_ack, b_ack, a_ack2, b_ack2;
  logic [15:0] mem_addr, mem_addr2;
  logic        mem_ce_n, mem_oe_n, busy, mem_ce_n2, mem_oe_n2, busy2;

  logic [7:0]  mem [65536];

  always #5 CLK = ~CLK;

  assign mem_data  = mem[mem_addr];
  assign mem_data2 = mem[mem_addr2];

  clut_prom_arbiter dut (
    .CLK(CLK), .rst(rst),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack),
    .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack),
    .mem_addr(mem_addr), .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n),
    .mem_data(mem_data), .busy(busy)
  );

  // Second instance with a 3S base near the top of the space to exercise address wrap.
  clut_prom_arbiter #(.BASE_3S(16'hFF00)) dut_wrap (
    .CLK(CLK), .rst(rst),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data2), .a_ack(a_ack2),
    .b_req(b_req), .b_addr(b_addr), .b_data(b_data2), .b_ack(b_ack2),
    .mem_addr(mem_addr2), .mem_ce_n(mem_ce_n2), .mem_oe_n(mem_oe_n2),
    .mem_data(mem_data2), .busy(busy2)
  );

`ifdef CLUT_ARB_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model state.
  bit         m_last_b;
  logic [7:0] m_a_data;
  logic [3:0] m_b_data;
  bit         m_valid [2];
  logic [8:0] m_tag [2];

  task automatic model_reset();
    m_last_b = 1'b1;
    m_a_data = 8'd0;
    m_b_data = 4'd0;
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 9'd0;
    end
  endtask

  typedef struct {
    int          port;
    int          cyc;
    logic [7:0]  data;
    bit          hit;
    logic [15:0] addr;
    logic [15:0] addr2;
  } exp_t;

  // Each requesting port asks for 'reps' lookups, holding req high between them.
  task automatic run(input bit ra, input bit rb, input logic [8:0] aa, input logic [8:0] ab,
                     input int reps);
    exp_t       q[$];
    exp_t       e;
    int         rem [2];
    logic [8:0] ad [2];
    int         t, p, cyc;
    bit         h;
    rem[0] = ra ? reps : 0;
    rem[1] = rb ? reps : 0;
    ad[0]  = aa;
    ad[1]  = ab;
    t      = 0;
    while (rem[0] > 0 || rem[1] > 0) begin
      if (rem[0] > 0 && rem[1] > 0) p = m_last_b ? 0 : 1;
      else                          p = (rem[0] > 0) ? 0 : 1;
      h = CACHE && m_valid[p] && (m_tag[p] == ad[p]);
      t += h ? 2 : 5;
      e.port  = p;
      e.cyc   = t - 1;
      e.hit   = h;
      e.addr  = p ? 16'h0200 + {7'b0, ad[1]} : {7'b0, ad[0]};
      e.addr2 = p ? 16'hFF00 + {7'b0, ad[1]} : {7'b0, ad[0]};
      if (!h) begin
        if (p == 1) m_b_data = mem[e.addr][3:0];
        else        m_a_data = mem[e.addr];
        m_valid[p] = 1'b1;
        m_tag[p]   = ad[p];
      end
      e.data   = p ? {4'b0, m_b_data} : m_a_data;
      m_last_b = (p == 1);
      rem[p]--;
      q.push_back(e);
    end

    rem[0] = ra ? reps : 0;
    rem[1] = rb ? reps : 0;
    a_addr = aa;
    b_addr = ab;
    a_req  = ra;
    b_req  = rb;
    cyc    = 0;
    while (q.size() > 0 && cyc < 200) begin
      @(negedge CLK);
      cyc++;
      check("dual_ack", {31'b0, a_ack & b_ack}, 0);
      if (a_ack || b_ack) begin
        e = q.pop_front();
        p = b_ack ? 1 : 0;
        check("ack_port", p, e.port);
        check("ack_cycle", cyc, e.cyc);
        check("ack_data", p ? {4'b0, b_data} : a_data, e.data);
        check("ce_n_capture", {31'b0, mem_ce_n}, {31'b0, e.hit});
        check("oe_n_capture", {31'b0, mem_oe_n}, {31'b0, e.hit});
        check("busy_capture", {31'b0, busy}, 1);
        if (!e.hit) begin
          check("mem_addr", {16'b0, mem_addr}, {16'b0, e.addr});
          check("mem_addr_wrap", {16'b0, mem_addr2}, {16'b0, e.addr2});
        end
        $display("txn port=%s addr=%03h hit=%0d cyc=%0d data=%02h mem_addr=%04h",
                 p ? "B" : "A", p ? ab : aa, e.hit, cyc, p ? {4'b0, b_data} : a_data, mem_addr);
        rem[p]--;
        if (rem[p] == 0) begin
          if (p == 1) b_req = 1'b0;
          else        a_req = 1'b0;
        end
      end
    end
    check("txn_timeout", q.size(), 0);
    a_req = 1'b0;
    b_req = 1'b0;
    @(negedge CLK);
    check("end_a_data", {24'b0, a_data}, {24'b0, m_a_data});
    check("end_b_data", {28'b0, b_data}, {28'b0, m_b_data});
    check("end_busy", {31'b0, busy}, 0);
    check("end_ce_n", {31'b0, mem_ce_n}, 1);
  endtask

  typedef struct {
    bit         ra, rb;
    logic [8:0] aa, ab;
    logic [7:0] am, bm;
    logic [7:0] exp_a;
    logic [3:0] exp_b;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    vecs[0] = '{1, 0, 9'h1FF, 9'h000, 8'hA5, 8'h00, 8'hA5, 4'h0};
    vecs[1] = '{0, 1, 9'h000, 9'h003, 8'h00, 8'h3C, 8'hA5, 4'hC};
    vecs[2] = '{1, 0, 9'h010, 9'h000, 8'h11, 8'h00, 8'h11, 4'hC};
    vecs[3] = '{1, 0, 9'h010, 9'h000, 8'h22, 8'h00, CACHE ? 8'h11 : 8'h22, 4'hC};
    vecs[4] = '{1, 0, 9'h011, 9'h000, 8'h33, 8'h00, 8'h33, 4'hC};
    vecs[5] = '{1, 1, 9'h020, 9'h1FF, 8'h44, 8'h5E, 8'h44, 4'hE};

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    model_reset();

    repeat (3) @(negedge CLK);
    check("rst_a_data", {24'b0, a_data}, 0);
    check("rst_b_data", {28'b0, b_data}, 0);
    check("rst_a_ack", {31'b0, a_ack}, 0);
    check("rst_b_ack", {31'b0, b_ack}, 0);
    check("rst_mem_addr", {16'b0, mem_addr}, 0);
    check("rst_ce_n", {31'b0, mem_ce_n}, 1);
    check("rst_oe_n", {31'b0, mem_oe_n}, 1);
    check("rst_busy", {31'b0, busy}, 0);
    rst = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].ra) mem[{7'b0, vecs[i].aa}] = vecs[i].am;
      if (vecs[i].rb) mem[16'h0200 + {7'b0, vecs[i].ab}] = vecs[i].bm;
      run(vecs[i].ra, vecs[i].rb, vecs[i].aa, vecs[i].ab, 1);
      check("vec_a_data", {24'b0, a_data}, {24'b0, vecs[i].exp_a});
      check("vec_b_data", {28'b0, b_data}, {28'b0, vecs[i].exp_b});
    end

    // Reset while the A lookup is in its first wait state.
    mem[16'h0012] = 8'h77;
    a_addr = 9'h012;
    a_req  = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("wait_busy", {31'b0, busy}, 1);
    check("wait_ce_n", {31'b0, mem_ce_n}, 0);
    rst = 1'b1;
    #1;
    check("abort_ce_n", {31'b0, mem_ce_n}, 1);
    check("abort_busy", {31'b0, busy}, 0);
    check("abort_a_data", {24'b0, a_data}, 0);
    check("abort_a_ack", {31'b0, a_ack}, 0);
    a_req = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    rst = 1'b0;
    model_reset();
    run(1, 0, 9'h012, 9'h000, 1);

    // Both ports requesting continuously: strict alternation.
    mem[16'h00AA] = 8'h5A;
    mem[16'h0255] = 8'h69;
    run(1, 1, 9'h0AA, 9'h055, 3);

    for (int it = 0; it < 40; it++) begin
      bit         ra, rb;
      logic [8:0] aa, ab;
      ra = 1'($urandom_range(0, 1));
      rb = ra ? 1'($urandom_range(0, 1)) : 1'b1;
      aa = $urandom_range(0, 1) ? 9'($urandom_range(0, 3)) : 9'($urandom);
      ab = $urandom_range(0, 1) ? 9'($urandom_range(0, 3)) : 9'($urandom);
      mem[{7'b0, aa}] = 8'($urandom);
      mem[16'h0200 + {7'b0, ab}] = 8'($urandom);
      run(ra, rb, aa, ab, $urandom_range(1, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
